event_framer: RTL and testbench
===============================

Name: event_framer

Overview:
- Sits directly downstream of the trigger/acquisition block and upstream of the AXI DMA S2MM.
- Takes the trigger's 64-bit event stream (TUSER marks the first word, TLAST the last) and wraps each event in a frame: one header word before the data, one trailer word after it.
- Header carries a running event number; trailer carries the data word count and error flags, so software can delimit and validate events in DMA memory.
- Overlong and unterminated events are cut cleanly, so a bad event never corrupts DMA framing.

Parameters:
- DATA_WIDTH, 64, stream width on both sides; fixed at 64 by the frame format.
- EVT_CNT_WIDTH, 32, event number counter width; must be ≤ 32.
- MAX_EVT_WORDS, 256, maximum data words per frame before forced truncation; must be in 1..65535.

Ports:
- AXIS_ACLK  in  1  clock.
- AXIS_ARESETN  in  1  reset; asynchronous assertion, active-low.
- S_AXIS_TDATA  in  64  event data from the trigger stage.
- S_AXIS_TVALID  in  1  input word valid.
- S_AXIS_TREADY  out  1  input accept.
- S_AXIS_TLAST  in  1  last data word of the event.
- S_AXIS_TUSER  in  1  first data word of the event.
- M_AXIS_TDATA  out  64  framed output to DMA.
- M_AXIS_TVALID  out  1  output valid.
- M_AXIS_TREADY  in  1  DMA ready.
- M_AXIS_TLAST  out  1  high on the trailer word only.
- O_EVENT_COUNT  out  EVT_CNT_WIDTH  number of trailers emitted.
- O_TRUNC_PULSE  out  1  one-cycle pulse when a truncated trailer is emitted.

Behaviour:
- Reset (AXIS_ARESETN low, asynchronous):
  - state=IDLE; all counters 0.
  - M_AXIS_TVALID, M_AXIS_TLAST, O_TRUNC_PULSE, S_AXIS_TREADY = 0.
  - M_AXIS_TDATA = 0; O_EVENT_COUNT = 0.
  - Reset mid-frame drops the partial frame; no trailer is emitted.
- Output register:
  - Single output register (skid-free). Once M_AXIS_TVALID=1, TDATA and TLAST hold until M_AXIS_TREADY=1.
  - The register may load when it is empty or when it is being drained in the same cycle.
- Input handshake:
  - S_AXIS_TREADY=1 only in DATA or DROP state, and in DATA only when the output register can load.
  - S_AXIS_TREADY is 0 in IDLE, HEADER and TRAILER.
  - Latency from input accept to appearing on M_AXIS_TDATA is 1 cycle.
- Header word: [63:48]=16'hAA55, [47:32]=16'h0000, [31:0]=event number zero-extended from EVT_CNT_WIDTH.
- Trailer word:
  - [63:48]=16'h55AA, [47:42]=0, [41]=missing_last, [40]=truncated, [39:32]=0.
  - [31:16]=data word count (header and trailer excluded).
  - [15:0]=checksum field (see Optional Feature).
- State machine:
  - IDLE: S_AXIS_TVALID=1 (TUSER not required) → HEADER. The input word is not accepted yet.
  - HEADER: load the header into the output register; clear word count, flags and checksum → DATA.
  - DATA: on each accepted word, word count +1 and the word is forwarded.
    - Accepted word with TLAST=1 → TRAILER.
    - Word count reaches MAX_EVT_WORDS with TLAST=0 → truncated=1 → TRAILER, then DROP.
    - TVALID=1 with TUSER=1 while word count>0: the word is not accepted; missing_last=1 → TRAILER → IDLE. The new event then starts normally.
  - TRAILER: load the trailer with TLAST=1. On load: O_EVENT_COUNT and event number +1, O_TRUNC_PULSE=truncated for 1 cycle. Next state is IDLE, or DROP if the frame was truncated.
  - DROP: accept and discard input words until an accepted word has TLAST=1 → IDLE. A TUSER=1 word seen in DROP is not accepted; go to IDLE and start a new frame from it.
- TLAST and TUSER on the same word: single-word event; count=1, no flags.
- TLAST arriving exactly on word MAX_EVT_WORDS: normal close, truncated=0, no DROP.
- Event number and O_EVENT_COUNT wrap from 2^EVT_CNT_WIDTH−1 to 0.
- Throughput: minimum frame overhead is 2 cycles, plus 1 IDLE cycle between frames.

Optional Feature:
- EVENT_FRAMER_CHECKSUM_EN defined:
  - Trailer [15:0] = XOR of the four 16-bit lanes of every forwarded data word in the frame.
  - Checksum clears in HEADER.
  - Words discarded in DROP are excluded.
- Undefined: trailer [15:0] = 16'h0000 and no checksum logic is synthesized.

Test Plan:
- Reset, then 3-word event D0,D1,D2 (TUSER on D0, TLAST on D2), M_AXIS_TREADY=1 → output 64'hAA55_0000_0000_0000, D0, D1, D2, 64'h55AA_0000_0003_xxxx with TLAST on the last word; O_EVENT_COUNT=1.
- MAX_EVT_WORDS=4, 6-word event → header, 4 data words, trailer [40]=1 with count=4, O_TRUNC_PULSE for 1 cycle; words 5 and 6 consumed and dropped.
- TUSER arrives after 2 words with no TLAST → trailer [41]=1, count=2; next frame header carries event number 1 and starts with the TUSER word.
- Random M_AXIS_TREADY (50%) over 100 events of random length 1–20 → no output word lost or duplicated, TDATA stable while stalled, counts match.
- O_EVENT_COUNT forced near max (EVT_CNT_WIDTH=4, 17 events) → header event numbers 0..15 then 0; O_EVENT_COUNT wraps to 1 after event 17.
- With EVENT_FRAMER_CHECKSUM_EN, words 64'h0001_0002_0004_0008 and 64'h0010_0020_0040_0080 → trailer [15:0]=16'h00FF; without the macro, 16'h0000.

Source files
------------

// File: rtl/event_framer.sv
// Wraps each 64-bit trigger event in a header/trailer frame for the DMA.
// Optional macro EVENT_FRAMER_CHECKSUM_EN adds a 16-bit lane-XOR checksum to the trailer.
module event_framer #(
  parameter int DATA_WIDTH    = 64,
  parameter int EVT_CNT_WIDTH = 32,
  parameter int MAX_EVT_WORDS = 256
) (
  input  logic                     AXIS_ACLK,
  input  logic                     AXIS_ARESETN,
  input  logic [DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic                     S_AXIS_TVALID,
  output logic                     S_AXIS_TREADY,
  input  logic                     S_AXIS_TLAST,
  input  logic                     S_AXIS_TUSER,
  output logic [DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic                     M_AXIS_TVALID,
  input  logic                     M_AXIS_TREADY,
  output logic                     M_AXIS_TLAST,
  output logic [EVT_CNT_WIDTH-1:0] O_EVENT_COUNT,
  output logic                     O_TRUNC_PULSE
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_DATA    = 3'd2,
    ST_TRAILER = 3'd3,
    ST_DROP    = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_last_q, out_last_d;
  logic                     trunc_pulse_q, trunc_pulse_d;
  logic [EVT_CNT_WIDTH-1:0] evt_cnt_q, evt_cnt_d;
  logic [15:0]              word_cnt_q, word_cnt_d;
  logic                     truncated_q, truncated_d;
  logic                     missing_last_q, missing_last_d;
  logic                     can_load_s;
  logic                     new_evt_s;
  logic                     in_ready_s;
  logic [15:0]              word_cnt_inc_s;
  logic [31:0]              evt_num_s;
  logic [15:0]              cksum_field_s;

`ifdef EVENT_FRAMER_CHECKSUM_EN
  logic [15:0] cksum_q, cksum_d;

  function automatic logic [15:0] lane_fold(input logic [63:0] w);
    return w[63:48] ^ w[47:32] ^ w[31:16] ^ w[15:0];
  endfunction
`endif

  // Next-state, output register load and input handshake
  always_comb begin
    state_d        = state_q;
    out_data_d     = out_data_q;
    out_valid_d    = out_valid_q && !M_AXIS_TREADY;
    out_last_d     = out_last_q;
    trunc_pulse_d  = 1'b0;
    evt_cnt_d      = evt_cnt_q;
    word_cnt_d     = word_cnt_q;
    truncated_d    = truncated_q;
    missing_last_d = missing_last_q;
    in_ready_s     = 1'b0;
`ifdef EVENT_FRAMER_CHECKSUM_EN
    cksum_d        = cksum_q;
    cksum_field_s  = cksum_q;
`else
    cksum_field_s  = 16'h0000;
`endif
    can_load_s     = !out_valid_q || M_AXIS_TREADY;
    new_evt_s      = S_AXIS_TVALID && S_AXIS_TUSER && (word_cnt_q != 16'd0);
    word_cnt_inc_s = word_cnt_q + 16'd1;
    evt_num_s      = 32'd0;
    evt_num_s[EVT_CNT_WIDTH-1:0] = evt_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (S_AXIS_TVALID) begin
          state_d = ST_HEADER;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HEADER: begin
        if (can_load_s) begin
          out_data_d     = {16'hAA55, 16'h0000, evt_num_s};
          out_valid_d    = 1'b1;
          out_last_d     = 1'b0;
          word_cnt_d     = 16'd0;
          truncated_d    = 1'b0;
          missing_last_d = 1'b0;
`ifdef EVENT_FRAMER_CHECKSUM_EN
          cksum_d        = 16'h0000;
`endif
          state_d        = ST_DATA;
        end else begin
          state_d = ST_HEADER;
        end
      end
      ST_DATA: begin
        // A new first-word mid-event closes the current frame without consuming it
        if (new_evt_s) begin
          missing_last_d = 1'b1;
          state_d        = ST_TRAILER;
        end else begin
          in_ready_s = can_load_s;
          if (S_AXIS_TVALID && can_load_s) begin
            out_data_d  = S_AXIS_TDATA;
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
            word_cnt_d  = word_cnt_inc_s;
`ifdef EVENT_FRAMER_CHECKSUM_EN
            cksum_d     = cksum_q ^ lane_fold(S_AXIS_TDATA);
`endif
            if (S_AXIS_TLAST) begin
              state_d = ST_TRAILER;
            end else if (word_cnt_inc_s == 16'(MAX_EVT_WORDS)) begin
              truncated_d = 1'b1;
              state_d     = ST_TRAILER;
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_TRAILER: begin
        if (can_load_s) begin
          out_data_d    = {16'h55AA, 6'd0, missing_last_q, truncated_q, 8'h00,
                           word_cnt_q, cksum_field_s};
          out_valid_d   = 1'b1;
          out_last_d    = 1'b1;
          evt_cnt_d     = evt_cnt_q + EVT_CNT_WIDTH'(1);
          trunc_pulse_d = truncated_q;
          state_d       = truncated_q ? ST_DROP : ST_IDLE;
        end else begin
          state_d = ST_TRAILER;
        end
      end
      ST_DROP: begin
        if (S_AXIS_TVALID && S_AXIS_TUSER) begin
          state_d = ST_IDLE;
        end else begin
          in_ready_s = 1'b1;
          if (S_AXIS_TVALID && S_AXIS_TLAST) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DROP;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, output register and counters
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q        <= ST_IDLE;
      out_data_q     <= '0;
      out_valid_q    <= 1'b0;
      out_last_q     <= 1'b0;
      trunc_pulse_q  <= 1'b0;
      evt_cnt_q      <= '0;
      word_cnt_q     <= 16'd0;
      truncated_q    <= 1'b0;
      missing_last_q <= 1'b0;
`ifdef EVENT_FRAMER_CHECKSUM_EN
      cksum_q        <= 16'h0000;
`endif
    end else begin
      state_q        <= state_d;
      out_data_q     <= out_data_d;
      out_valid_q    <= out_valid_d;
      out_last_q     <= out_last_d;
      trunc_pulse_q  <= trunc_pulse_d;
      evt_cnt_q      <= evt_cnt_d;
      word_cnt_q     <= word_cnt_d;
      truncated_q    <= truncated_d;
      missing_last_q <= missing_last_d;
`ifdef EVENT_FRAMER_CHECKSUM_EN
      cksum_q        <= cksum_d;
`endif
    end
  end

  assign S_AXIS_TREADY = in_ready_s;
  assign M_AXIS_TDATA  = out_data_q;
  assign M_AXIS_TVALID = out_valid_q;
  assign M_AXIS_TLAST  = out_last_q;
  assign O_EVENT_COUNT = evt_cnt_q;
  assign O_TRUNC_PULSE = trunc_pulse_q;

endmodule

// File: tb/tb_event_framer.sv
// Self-checking bench for event_framer: directed cases plus randomized traffic
// compared against a stream-level frame model.
module tb_event_framer;

  localparam int MAXW = 4;
  localparam int EVW  = 4;

  logic            clk;
  logic            rst_n;
  logic [63:0]     s_tdata;
  logic            s_tvalid;
  logic            s_tready;
  logic            s_tlast;
  logic            s_tuser;
  logic [63:0]     m_tdata;
  logic            m_tvalid;
  logic            m_tready;
  logic            m_tlast;
  logic [EVW-1:0]  o_event_count;
  logic            o_trunc;

  event_framer #(.DATA_WIDTH(64), .EVT_CNT_WIDTH(EVW), .MAX_EVT_WORDS(MAXW)) dut (
    .AXIS_ACLK    (clk),
    .AXIS_ARESETN (rst_n),
    .S_AXIS_TDATA (s_tdata),
    .S_AXIS_TVALID(s_tvalid),
    .S_AXIS_TREADY(s_tready),
    .S_AXIS_TLAST (s_tlast),
    .S_AXIS_TUSER (s_tuser),
    .M_AXIS_TDATA (m_tdata),
    .M_AXIS_TVALID(m_tvalid),
    .M_AXIS_TREADY(m_tready),
    .M_AXIS_TLAST (m_tlast),
    .O_EVENT_COUNT(o_event_count),
    .O_TRUNC_PULSE(o_trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] in_data[$];
  logic        in_user[$];
  logic        in_last[$];
  int          in_idx;
  logic [63:0] exp_data[$];
  logic        exp_last[$];
  logic [63:0] obs_data[$];

  int          vprob, rprob;
  logic        hold_pend, hold_last, prev_pulse;
  logic [63:0] hold_data;
  int          trunc_seen;

  // stream-level model: mode 0 = between frames, 1 = in frame, 2 = discarding
  int          m_mode, m_evn, m_cnt, m_truncs;
  logic [15:0] m_cks;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, expv);
    end
  endtask

  task automatic model_trailer(input logic miss, input logic trunc);
    logic [15:0] ck;
`ifdef EVENT_FRAMER_CHECKSUM_EN
    ck = m_cks;
`else
    ck = 16'h0000;
`endif
    exp_data.push_back({16'h55AA, 6'd0, miss, trunc, 8'h00, 16'(m_cnt), ck});
    exp_last.push_back(1'b1);
    m_evn = (m_evn + 1) % (1 << EVW);
    if (trunc) m_truncs++;
  endtask

  task automatic add_word(input logic [63:0] d, input logic u, input logic l);
    bit again;
    in_data.push_back(d); in_user.push_back(u); in_last.push_back(l);
    again = 1'b1;
    while (again) begin
      again = 1'b0;
      if (m_mode == 0) begin
        exp_data.push_back({16'hAA55, 16'h0000, 32'(m_evn)});
        exp_last.push_back(1'b0);
        m_cnt = 0; m_cks = 16'h0000; m_mode = 1; again = 1'b1;
      end else if (m_mode == 1) begin
        if (u && m_cnt > 0) begin
          model_trailer(1'b1, 1'b0);
          m_mode = 0; again = 1'b1;
        end else begin
          exp_data.push_back(d); exp_last.push_back(1'b0);
          m_cnt++;
          m_cks = m_cks ^ d[63:48] ^ d[47:32] ^ d[31:16] ^ d[15:0];
          if (l) begin
            model_trailer(1'b0, 1'b0); m_mode = 0;
          end else if (m_cnt == MAXW) begin
            model_trailer(1'b0, 1'b1); m_mode = 2;
          end
        end
      end else begin
        if (u) begin
          m_mode = 0; again = 1'b1;
        end else if (l) begin
          m_mode = 0;
        end
      end
    end
  endtask

  task automatic new_phase(input int vp, input int rp);
    in_data.delete(); in_user.delete(); in_last.delete();
    exp_data.delete(); exp_last.delete(); obs_data.delete();
    in_idx = 0; vprob = vp; rprob = rp;
  endtask

  task automatic step();
    logic acc;
    @(negedge clk);
    if (hold_pend) begin
      chk("stall_valid", 64'(m_tvalid), 64'd1);
      chk("stall_data", m_tdata, hold_data);
      chk("stall_last", 64'(m_tlast), 64'(hold_last));
    end
    if (m_tvalid && m_tready) begin
      obs_data.push_back(m_tdata);
      if (exp_data.size() == 0) begin
        chk("extra_word_pending", 64'(exp_data.size()), 64'd1);
      end else begin
        chk("out_data", m_tdata, exp_data.pop_front());
        chk("out_last", 64'(m_tlast), 64'(exp_last.pop_front()));
      end
    end
    hold_pend = m_tvalid && !m_tready;
    hold_data = m_tdata;
    hold_last = m_tlast;
    if (o_trunc) begin
      trunc_seen++;
      chk("trunc_on_trailer", {62'd0, m_tlast, m_tdata[40]}, 64'd3);
      chk("trunc_one_cycle", 64'(prev_pulse), 64'd0);
    end
    prev_pulse = o_trunc;
    acc = s_tvalid && s_tready;
    @(posedge clk); #1;
    if (acc) in_idx++;
    if (in_idx < in_data.size()) begin
      if (!(s_tvalid && !acc)) s_tvalid = ($urandom_range(99) < vprob);
      s_tdata = in_data[in_idx];
      s_tuser = in_user[in_idx];
      s_tlast = in_last[in_idx];
    end else begin
      s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    end
    m_tready = ($urandom_range(99) < rprob);
  endtask

  task automatic run_phase(input string tag, input int limit);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(in_idx >= in_data.size() && exp_data.size() == 0 && !m_tvalid) && n < limit);
    chk({tag, "_timeout"}, 64'(n >= limit), 64'd0);
    chk({tag, "_event_count"}, 64'(o_event_count), 64'(m_evn));
    chk({tag, "_trunc_count"}, 64'(trunc_seen), 64'(m_truncs));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; s_tvalid = 1'b1; s_tuser = 1'b1; s_tlast = 1'b0; s_tdata = 64'd0;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tlast", 64'(m_tlast), 64'd0);
    chk("rst_m_tdata", m_tdata, 64'd0);
    chk("rst_event_count", 64'(o_event_count), 64'd0);
    chk("rst_trunc", 64'(o_trunc), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tuser = 1'b0;
    rst_n = 1'b1;
    m_mode = 0; m_evn = 0; m_cnt = 0; m_cks = 16'h0000; m_truncs = 0;
    hold_pend = 1'b0; prev_pulse = 1'b0; trunc_seen = 0;
  endtask

  initial begin
    int len;
    logic drop_last;
    logic [15:0] ck_exp;
    rst_n = 1'b0;
    do_reset();

    // 3-word event, sink always ready
    new_phase(100, 100);
    add_word(64'h1111_2222_3333_4444, 1'b1, 1'b0);
    add_word(64'h5555_6666_7777_8888, 1'b0, 1'b0);
    add_word(64'h9999_AAAA_BBBB_CCCC, 1'b0, 1'b1);
    run_phase("basic", 200);
    chk("basic_words", 64'(obs_data.size()), 64'd5);
    chk("basic_header", obs_data[0], 64'hAA55_0000_0000_0000);
    chk("basic_d0", obs_data[1], 64'h1111_2222_3333_4444);
    chk("basic_d2", obs_data[3], 64'h9999_AAAA_BBBB_CCCC);
    chk("basic_trailer", 64'(obs_data[4][63:16]), 64'h55AA_0000_0003);
    chk("basic_evcount", 64'(o_event_count), 64'd1);

    // 6-word event truncated at 4
    new_phase(100, 100);
    for (int i = 0; i < 6; i++) add_word(64'hD0 + 64'(i), i == 0, i == 5);
    run_phase("trunc", 200);
    chk("trunc_words", 64'(obs_data.size()), 64'd6);
    chk("trunc_flag", 64'(obs_data[5][41:40]), 64'd1);
    chk("trunc_wcount", 64'(obs_data[5][31:16]), 64'd4);
    chk("trunc_pulses", 64'(trunc_seen), 64'd1);

    // new TUSER after 2 words without TLAST
    new_phase(100, 100);
    add_word(64'hA0, 1'b1, 1'b0);
    add_word(64'hA1, 1'b0, 1'b0);
    add_word(64'hB0, 1'b1, 1'b0);
    add_word(64'hB1, 1'b0, 1'b1);
    run_phase("missing", 200);
    chk("miss_flags", 64'(obs_data[3][41:40]), 64'd2);
    chk("miss_wcount", 64'(obs_data[3][31:16]), 64'd2);
    chk("miss_hdr1_num", 64'(obs_data[0][31:0]), 64'd2);
    chk("miss_hdr2_num", 64'(obs_data[4][31:0]), 64'd3);
    chk("miss_new_first", obs_data[5], 64'hB0);

    // checksum lane fold
    new_phase(100, 100);
    add_word(64'h0001_0002_0004_0008, 1'b1, 1'b0);
    add_word(64'h0010_0020_0040_0080, 1'b0, 1'b1);
    run_phase("cksum", 200);
`ifdef EVENT_FRAMER_CHECKSUM_EN
    ck_exp = 16'h00FF;
`else
    ck_exp = 16'h0000;
`endif
    chk("cksum_field", 64'(obs_data[3][15:0]), 64'(ck_exp));

    // 100 random events with 50% sink backpressure
    new_phase(80, 50);
    for (int e = 0; e < 100; e++) begin
      len = $urandom_range(20, 1);
      drop_last = (e != 99) && ($urandom_range(7) == 0);
      for (int w = 0; w < len; w++)
        add_word({$urandom, $urandom}, w == 0, (w == len - 1) && !drop_last);
    end
    run_phase("random", 40000);

    // event number wrap over 17 single-word events
    do_reset();
    new_phase(100, 100);
    for (int e = 0; e < 17; e++) add_word(64'hE00 + 64'(e), 1'b1, 1'b1);
    run_phase("wrap", 500);
    for (int e = 0; e < 17; e++)
      chk("wrap_hdr_num", 64'(obs_data[3 * e][31:0]), 64'(e % 16));
    chk("wrap_evcount", 64'(o_event_count), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
